// File: rtl/im_access_ctrl_pkg.sv
// Shared definitions for the instruction-memory access controller:
// FSM state encoding, read-owner tag encoding and default bus widths.
package im_access_ctrl_pkg;

    localparam int AW_DEF = 10;  // word address, byte addr[11:2] of a 4 KB memory
    localparam int DW_DEF = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Which requester owns the read currently in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } owner_t;

endpackage

// File: rtl/im_access_ctrl_if.sv
// Bundle of the three buses around the controller: IF-stage fetch port,
// loader/debug port and the single synchronous-read memory port.
// Modports:
//   slave  - controller view (takes requests, drives the memory port)
//   master - environment view (IF stage, loader and memory model)
interface im_access_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_stall;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    // loader port
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_done;
    logic          ld_gnt;
    logic          ld_valid;
    logic [DW-1:0] ld_rdata;
    // run gate for the pipeline
    logic          cpu_run;
    // memory port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rdata,
        output if_stall, if_valid, if_rdata, ld_gnt, ld_valid, ld_rdata, cpu_run,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rdata,
        input  if_stall, if_valid, if_rdata, ld_gnt, ld_valid, ld_rdata, cpu_run,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/im_starve_cnt.sv
// Saturating up-counter with synchronous clear. Counts cycles the loader
// has been refused; at_max flags that the next loader request must win.
// Ports: clk, rst (sync, active high), clr (priority over en), en,
//        cnt (current count), at_max (cnt == STARVE_MAX).
module im_starve_cnt #(
    parameter int STARVE_MAX = 8,
    localparam int CW = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    assign at_max = (cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !at_max)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/im_access_ctrl.sv
// Arbitrates the single port of a 1-cycle-latency instruction RAM between
// the IF stage (read only) and a loader/debug master (read/write).
// BOOT: loader owns the port, fetch is stalled. ld_done moves to RUN.
// RUN : fetch wins, except the loader is forced through after STARVE_MAX
//       consecutive refused cycles. Only rst returns to BOOT.
// Ports: clk, rst (sync, active high), bus (im_access_ctrl_if.slave).
module im_access_ctrl
    import im_access_ctrl_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    im_access_ctrl_if.slave   bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    state_t        state, state_nxt;
    owner_t        owner;
    logic          rd_pend;
    logic          if_gnt, ld_gnt, force_ld;
    logic          cnt_clr, cnt_en, at_max;
    logic [CW-1:0] starve_cnt;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        if (state == BOOT && bus.ld_done)
            state_nxt = RUN;
    end

    // ---------------- grants ----------------
    always_comb begin
        force_ld = 1'b0;
        if_gnt   = 1'b0;
        ld_gnt   = 1'b0;
        if (state == BOOT) begin
            ld_gnt = bus.ld_req;
        end else begin
            force_ld = at_max && bus.ld_req;
            if_gnt   = bus.if_req && !force_ld;
            ld_gnt   = bus.ld_req && (!bus.if_req || force_ld);
        end
    end

    // Counter only runs while the loader is actually being refused in RUN.
    assign cnt_clr = (state == BOOT) || ld_gnt || !bus.ld_req;
    assign cnt_en  = !cnt_clr;

    im_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .cnt    (starve_cnt),
        .at_max (at_max)
    );

    // ---------------- memory port ----------------
    assign addr_sel  = ld_gnt ? bus.ld_addr  : bus.if_addr;
    assign wdata_sel = ld_gnt ? bus.ld_wdata : '0;

    assign bus.mem_en    = if_gnt || ld_gnt;
    assign bus.mem_we    = ld_gnt && bus.ld_we;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;

    assign bus.if_stall = bus.if_req && !if_gnt;
    assign bus.ld_gnt   = ld_gnt;
    assign bus.cpu_run  = (state == RUN);

    // ---------------- read return ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            owner   <= OWN_IF;
        end else begin
            rd_pend <= (if_gnt || ld_gnt) && !bus.mem_we;
            owner   <= ld_gnt ? OWN_LD : OWN_IF;
        end
    end

    // rst also masks the return combinationally, so a read whose data is
    // already coming back when reset arrives never produces a valid pulse.
    assign bus.if_valid = rd_pend && !rst && (owner == OWN_IF);
    assign bus.ld_valid = rd_pend && !rst && (owner == OWN_LD);
    assign bus.if_rdata = bus.mem_rdata;
    assign bus.ld_rdata = bus.mem_rdata;

    // starve_cnt is observed only through at_max here; keep it named for debug.
    logic unused_cnt;
    assign unused_cnt = ^starve_cnt;

endmodule

// File: tb/tb_im_access_ctrl.sv
// Directed bench for im_access_ctrl with a 1-cycle synchronous-read RAM model.
module tb_im_access_ctrl;
    import im_access_ctrl_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    im_access_ctrl_if #(.AW(AW), .DW(DW)) bus();

    im_access_ctrl #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before checks.
    task automatic drive(input logic r, input logic ir, input logic [AW-1:0] ia,
                         input logic lr, input logic lw, input logic [AW-1:0] la,
                         input logic [DW-1:0] lwd, input logic ldn);
        @(negedge clk);
        rst          = r;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.ld_req   = lr;
        bus.ld_we    = lw;
        bus.ld_addr  = la;
        bus.ld_wdata = lwd;
        bus.ld_done  = ldn;
        #1;
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = '0; bus.ld_req = 0; bus.ld_we = 0;
        bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_done = 0;

        // reset
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_ld_valid", bus.ld_valid, 0);
        chk("rst_cpu_run",  bus.cpu_run,  0);

        // BOOT loader writes, fetch requesting throughout
        drive(0, 1, 0, 1, 1, 10'h000, 32'h2010_0005, 0);
        chk("boot_wr0_gnt",   bus.ld_gnt,   1);
        chk("boot_wr0_stall", bus.if_stall, 1);
        chk("boot_wr0_run",   bus.cpu_run,  0);
        chk("boot_wr0_we",    bus.mem_we,   1);
        chk("boot_wr0_addr",  bus.mem_addr, 0);
        chk("boot_wr0_wdata", bus.mem_wdata, 32'h2010_0005);
        drive(0, 1, 0, 1, 1, 10'h001, 32'h0000_0000, 0);
        chk("boot_wr1_gnt",   bus.ld_gnt,   1);
        chk("boot_wr1_stall", bus.if_stall, 1);
        chk("boot_wr1_we",    bus.mem_we,   1);
        chk("boot_wr1_addr",  bus.mem_addr, 1);

        // ld_done with a loader read in the same cycle
        drive(0, 1, 0, 1, 0, 10'h000, 0, 1);
        chk("done_rd_gnt",   bus.ld_gnt,   1);
        chk("done_rd_we",    bus.mem_we,   0);
        chk("done_rd_stall", bus.if_stall, 1);
        chk("done_rd_run",   bus.cpu_run,  0);

        // RUN: fetch streaming from 0x000
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        chk("run_ld_valid", bus.ld_valid, 1);
        chk("run_ld_rdata", bus.ld_rdata, 32'h2010_0005);
        chk("run_cpu_run",  bus.cpu_run,  1);
        chk("run_stall0",   bus.if_stall, 0);
        chk("run_if_valid0", bus.if_valid, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0);
            chk("run_stall",    bus.if_stall, 0);
            chk("run_if_valid", bus.if_valid, 1);
            chk("run_if_rdata", bus.if_rdata, 32'h2010_0005);
        end

        // contention: loader read of 0x001 starves for 8 cycles, forced on 9th
        for (int k = 1; k <= 9; k++) begin
            drive(0, 1, 0, 1, 0, 10'h001, 0, 0);
            chk("starve_if_valid", bus.if_valid, 1);
            if (k < 9) begin
                chk("starve_ld_gnt", bus.ld_gnt,   0);
                chk("starve_stall",  bus.if_stall, 0);
            end else begin
                chk("force_ld_gnt", bus.ld_gnt,   1);
                chk("force_stall",  bus.if_stall, 1);
                chk("force_addr",   bus.mem_addr, 1);
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        chk("force_ld_valid", bus.ld_valid, 1);
        chk("force_ld_rdata", bus.ld_rdata, 0);
        chk("force_if_valid", bus.if_valid, 0);
        chk("force_cnt_clr",  dut.u_starve.cnt, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        chk("resume_if_valid", bus.if_valid, 1);
        chk("resume_if_rdata", bus.if_rdata, 32'h2010_0005);

        // loader alone in RUN: immediate grant; ld_done ignored
        drive(0, 0, 0, 1, 1, 10'h002, 32'hDEAD_BEEF, 1);
        chk("idle_ld_gnt",  bus.ld_gnt,   1);
        chk("idle_stall",   bus.if_stall, 0);
        chk("idle_we",      bus.mem_we,   1);
        chk("idle_wdata",   bus.mem_wdata, 32'hDEAD_BEEF);
        drive(0, 0, 0, 1, 0, 10'h002, 0, 0);
        chk("done_ign_run", bus.cpu_run,  1);
        chk("idle_rd_gnt",  bus.ld_gnt,   1);
        chk("idle_rd_we",   bus.mem_we,   0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_ld_valid", bus.ld_valid, 1);
        chk("idle_ld_rdata", bus.ld_rdata, 32'hDEAD_BEEF);
        chk("idle_mem_en",   bus.mem_en,   0);

        // reset right behind an IF read grant drops the return
        drive(0, 1, 10'h002, 0, 0, 0, 0, 0);
        chk("pre_rst_stall", bus.if_stall, 0);
        chk("pre_rst_en",    bus.mem_en,   1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("in_rst_if_valid", bus.if_valid, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_if_valid", bus.if_valid, 0);
        chk("post_rst_ld_valid", bus.ld_valid, 0);
        chk("post_rst_run",      bus.cpu_run,  0);
        chk("post_rst_stall",    bus.if_stall, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
